// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and the datapath.
// master: fetch/datapath side. slave: the decode stage.
interface instr_decode_stage_if #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int MEM_AW  = 10,
  parameter int DATA_W  = 8,
  parameter int PC_W    = 5
);
  logic               flush;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         operation_code;
  logic               aku_enable;
  logic               reg_ce;
  logic [REG_AW-1:0]  register_addr;
  logic               direct_load;
  logic [DATA_W-1:0]  direct_data;
  logic [MEM_AW-1:0]  mem_adr;
  logic               mem_wr;
  logic               mem_rd;
  logic               mem_rd_ack;
  logic               counter_load;
  logic [PC_W-1:0]    address_counter;

  modport master (
    output flush, instr, instr_valid, out_ready, mem_rd_ack,
    input  instr_ready, out_valid, operation_code, aku_enable, reg_ce, register_addr,
           direct_load, direct_data, mem_adr, mem_wr, mem_rd, counter_load, address_counter
  );

  modport slave (
    input  flush, instr, instr_valid, out_ready, mem_rd_ack,
    output instr_ready, out_valid, operation_code, aku_enable, reg_ce, register_addr,
           direct_load, direct_data, mem_adr, mem_wr, mem_rd, counter_load, address_counter
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered valid/ready instruction decode stage; stalls fetch during multi-cycle MUL
// and while an LD_M read waits for its acknowledge. Supports a synchronous flush.
module instr_decode_stage #(
  parameter int INSTR_W    = 16,
  parameter int REG_AW     = 3,
  parameter int MEM_AW     = 10,
  parameter int DATA_W     = 8,
  parameter int PC_W       = 5,
  parameter int MUL_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  instr_decode_stage_if.slave bus
);

  generate
    if (MUL_CYCLES < 1) begin : g_bad_mul_cycles
      $error("instr_decode_stage: MUL_CYCLES must be >= 1");
    end
  endgenerate

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, MUL_WAIT, MEM_WAIT} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic              aku;
    logic              reg_ce;
    logic [REG_AW-1:0] reg_addr;
    logic              direct_load;
    logic [DATA_W-1:0] direct_data;
    logic [MEM_AW-1:0] mem_adr;
    logic              mem_wr;
    logic              mem_rd;
    logic              counter_load;
    logic [PC_W-1:0]   addr_cnt;
  } fields_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             valid_q;
  logic             pending;
  fields_t          dec;
  fields_t          cur;
  fields_t          shown;
  logic             ready;
  logic             accept;
  logic             xfer;
  logic             stall_mul;
  logic             stall_mem;
  logic             unused_instr;

  assign unused_instr = ^bus.instr;

  always_comb begin
    dec    = '0;
    dec.op = bus.instr[INSTR_W-1 -: 4];
    casez (dec.op)
      4'b0???: begin
        dec.aku = 1'b1;
        if (bus.instr[8]) begin
          dec.direct_load = 1'b1;
          dec.direct_data = bus.instr[DATA_W-1:0];
        end else begin
          dec.reg_addr = bus.instr[REG_AW-1:0];
        end
      end
      4'b100?: begin
        dec.counter_load = 1'b1;
        dec.addr_cnt     = bus.instr[PC_W-1:0];
      end
      4'b101?: begin
        dec.mem_rd  = 1'b1;
        dec.aku     = 1'b1;
        dec.mem_adr = bus.instr[MEM_AW-1:0];
      end
      4'b110?: begin
        if (bus.instr[8]) begin
          dec.direct_load = 1'b1;
          dec.direct_data = bus.instr[DATA_W-1:0];
          dec.aku         = 1'b1;
        end else begin
          dec.reg_ce   = 1'b1;
          dec.reg_addr = bus.instr[REG_AW-1:0];
        end
      end
      default: begin
        dec.mem_wr  = 1'b1;
        dec.mem_adr = bus.instr[MEM_AW-1:0];
      end
    endcase
  end

  assign ready     = (state == RUN) && !bus.flush && (!valid_q || bus.out_ready);
  assign accept    = ready && bus.instr_valid;
  assign xfer      = valid_q && bus.out_ready;
  assign stall_mul = xfer && (MUL_CYCLES > 1) && (cur.op == 4'b0111);
  assign stall_mem = xfer && (cur.op[3:1] == 3'b101);

  // An instruction accepted in the same cycle a stalling op leaves is parked in
  // cur and only made visible (pending) once the stall has ended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      valid_q <= 1'b0;
      pending <= 1'b0;
      cur     <= '0;
    end else if (bus.flush) begin
      state   <= RUN;
      cnt     <= '0;
      valid_q <= 1'b0;
      pending <= 1'b0;
      cur     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (accept) cur <= dec;
          if (stall_mul || stall_mem) begin
            valid_q <= 1'b0;
            pending <= accept;
            state   <= stall_mul ? MUL_WAIT : MEM_WAIT;
            cnt     <= stall_mul ? CNT_W'(MUL_CYCLES - 1) : '0;
          end else if (accept) begin
            valid_q <= 1'b1;
          end else if (xfer) begin
            valid_q <= 1'b0;
          end
        end
        MUL_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state   <= RUN;
            cnt     <= '0;
            valid_q <= pending;
            pending <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_rd_ack) begin
            state   <= RUN;
            valid_q <= pending;
            pending <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Every field, strobes included, reads as zero whenever no valid output is presented.
  assign shown = valid_q ? cur : '0;

  assign bus.instr_ready     = ready;
  assign bus.out_valid       = valid_q;
  assign bus.operation_code  = shown.op;
  assign bus.aku_enable      = shown.aku;
  assign bus.reg_ce          = shown.reg_ce;
  assign bus.register_addr   = shown.reg_addr;
  assign bus.direct_load     = shown.direct_load;
  assign bus.direct_data     = shown.direct_data;
  assign bus.mem_adr         = shown.mem_adr;
  assign bus.mem_wr          = shown.mem_wr;
  assign bus.mem_rd          = shown.mem_rd;
  assign bus.counter_load    = shown.counter_load;
  assign bus.address_counter = shown.addr_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_instr_decode_stage;
  localparam int INSTR_W    = 16;
  localparam int REG_AW     = 3;
  localparam int MEM_AW     = 10;
  localparam int DATA_W     = 8;
  localparam int PC_W       = 5;
  localparam int MUL_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW),
                          .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  instr_decode_stage #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .DATA_W(DATA_W),
                       .PC_W(PC_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int passes = 0;
  bit seen_ready;

  // reference state: presented entry, remaining stall cycles, memory wait, parked entry
  bit          m_valid;
  logic [35:0] m_fields;
  int          m_stall;
  bit          m_mem;
  bit          m_pend;
  logic [35:0] m_pend_fields;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passes++;
  endtask

  function automatic logic [35:0] decodeRef(input int unsigned w);
    int unsigned op = (w >> 12) % 16;
    int unsigned imm = (w >> 8) % 2;
    int unsigned ra = 0, dd = 0, ma = 0, pc = 0;
    bit aku = 0, rce = 0, dl = 0, mw = 0, mr = 0, cl = 0;
    if (op < 8) begin
      aku = 1;
      if (imm == 1) begin dl = 1; dd = w % 256; end
      else ra = w % 8;
    end else if (op < 10) begin
      cl = 1; pc = w % 32;
    end else if (op < 12) begin
      mr = 1; aku = 1; ma = w % 1024;
    end else if (op < 14) begin
      if (imm == 1) begin dl = 1; dd = w % 256; aku = 1; end
      else begin rce = 1; ra = w % 8; end
    end else begin
      mw = 1; ma = w % 1024;
    end
    return {4'(op), aku, rce, 3'(ra), dl, 8'(dd), 10'(ma), mw, mr, cl, 5'(pc)};
  endfunction

  function automatic logic [35:0] dutFields();
    return {bus.operation_code, bus.aku_enable, bus.reg_ce, bus.register_addr, bus.direct_load,
            bus.direct_data, bus.mem_adr, bus.mem_wr, bus.mem_rd, bus.counter_load,
            bus.address_counter};
  endfunction

  function automatic void modelClear();
    m_valid = 0; m_fields = '0; m_stall = 0; m_mem = 0; m_pend = 0; m_pend_fields = '0;
  endfunction

  function automatic bit modelReady();
    return !bus.flush && (m_stall == 0) && !m_mem && (!m_valid || bus.out_ready);
  endfunction

  function automatic void modelRelease();
    m_valid = m_pend;
    if (m_pend) m_fields = m_pend_fields;
    m_pend = 0;
  endfunction

  function automatic void modelUpdate(input bit rdy);
    bit xfer, acc;
    int unsigned op;
    if (rst || bus.flush) begin
      modelClear();
    end else if (m_stall > 0) begin
      m_stall--;
      if (m_stall == 0) modelRelease();
    end else if (m_mem) begin
      if (bus.mem_rd_ack) begin m_mem = 0; modelRelease(); end
    end else begin
      xfer = m_valid && bus.out_ready;
      acc  = bus.instr_valid && rdy;
      op   = int'(m_fields[35:32]);
      if (xfer && ((op == 7 && MUL_CYCLES > 1) || op == 10 || op == 11)) begin
        if (op == 7) m_stall = MUL_CYCLES - 1;
        else m_mem = 1;
        m_valid = 0;
        m_pend  = acc;
        if (acc) m_pend_fields = decodeRef(bus.instr);
      end else if (acc) begin
        m_valid  = 1;
        m_fields = decodeRef(bus.instr);
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  endfunction

  // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    bit rdy;
    @(negedge clk);
    rdy = modelReady();
    checkOutput("out_valid", bus.out_valid, m_valid);
    checkOutput("fields", dutFields(), m_valid ? m_fields : 36'h0);
    checkOutput("instr_ready", bus.instr_ready, rdy);
    seen_ready = bus.instr_ready;
    modelUpdate(rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] ins, input bit vld, input bit ordy,
                               input bit fl, input bit ack);
    bus.instr = ins; bus.instr_valid = vld; bus.out_ready = ordy;
    bus.flush = fl; bus.mem_rd_ack = ack;
    step();
  endtask

  initial begin
    int zeros;
    bus.instr = '0; bus.instr_valid = 0; bus.out_ready = 0; bus.flush = 0; bus.mem_rd_ack = 0;
    modelClear();
    @(posedge clk);
    #1;
    step();
    rst = 0;
    applyStimulus(16'h0000, 0, 0, 0, 0);
    checkOutput("t1_ready", bus.instr_ready, 1);
    checkOutput("t1_out_valid", bus.out_valid, 0);

    applyStimulus(16'h0105, 1, 1, 0, 0);
    checkOutput("t2_direct_data", bus.direct_data, 8'h05);
    checkOutput("t2_aku_dl_valid", {bus.aku_enable, bus.direct_load, bus.out_valid}, 3'b111);
    applyStimulus(16'h0000, 0, 1, 0, 0);

    applyStimulus(16'h7003, 1, 1, 0, 0);
    applyStimulus(16'h0000, 0, 1, 0, 0);
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'h0000, 0, 1, 0, 0);
      if (seen_ready) break;
      zeros++;
    end
    checkOutput("t3_stall_cycles", zeros, 3);

    applyStimulus(16'hA3FF, 1, 1, 0, 0);
    checkOutput("t4_mem_rd", bus.mem_rd, 1);
    checkOutput("t4_mem_adr", bus.mem_adr, 10'h3FF);
    applyStimulus(16'h0000, 0, 1, 0, 1);
    repeat (3) applyStimulus(16'h0000, 0, 1, 0, 0);
    applyStimulus(16'h0000, 0, 1, 0, 1);
    checkOutput("t4_ready_after_ack", bus.instr_ready, 1);

    applyStimulus(16'hE012, 1, 0, 0, 0);
    applyStimulus(16'h1234, 1, 0, 0, 0);
    applyStimulus(16'h1234, 1, 0, 0, 0);
    checkOutput("t5_mem_wr_held", {bus.mem_wr, bus.out_valid, bus.instr_ready}, 3'b110);
    checkOutput("t5_mem_adr_held", bus.mem_adr, 10'h012);
    applyStimulus(16'h0000, 0, 1, 0, 0);
    checkOutput("t5_ready_after_xfer", bus.instr_ready, 1);

    applyStimulus(16'hA005, 1, 1, 0, 0);
    applyStimulus(16'h0000, 0, 1, 0, 0);
    applyStimulus(16'h0105, 1, 1, 1, 0);
    checkOutput("t6_out_valid", bus.out_valid, 0);
    applyStimulus(16'h0105, 1, 1, 1, 0);
    applyStimulus(16'h0000, 0, 1, 0, 0);

    applyStimulus(16'h7101, 1, 1, 0, 0);
    applyStimulus(16'h0000, 0, 1, 0, 0);
    applyStimulus(16'h0000, 0, 1, 0, 0);
    rst = 1;
    modelClear();
    #1;
    checkOutput("reset_mid_mul", {bus.out_valid, bus.instr_ready}, 2'b01);
    step();
    rst = 0;
    applyStimulus(16'h0000, 0, 1, 0, 0);

    repeat (800) begin
      applyStimulus(16'($urandom), ($urandom % 10) < 7, ($urandom % 10) < 7,
                    ($urandom % 25) == 0, ($urandom % 4) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
